// File: rtl/des_pkg.sv
// Shared DES controller types: FSM states, key-schedule rotate tables, round count.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Element [i] is the C/D rotate amount for round i (index 15 listed first).
  localparam logic [DES_ROUNDS-1:0][1:0] ENC_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  // Decrypt rotates right; round 0 needs no rotate because C/D start at PC1(key).
  localparam logic [DES_ROUNDS-1:0][1:0] DEC_SHIFT = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0
  };

endpackage

// File: rtl/des_shift_schedule.sv
// Combinational key-schedule lookup: rotate amount and direction for the current round.
module des_shift_schedule
  import des_pkg::*;
(
  input  logic [3:0] round_idx,
  input  logic       mode,
  input  logic       round_en,
  output logic [1:0] shift_amt,
  output logic       shift_dir
);

  always_comb begin
    shift_amt = 2'd0;
    shift_dir = 1'b0;
    if (round_en) begin
      shift_amt = mode ? DEC_SHIFT[round_idx] : ENC_SHIFT[round_idx];
      shift_dir = mode;
    end
  end

endmodule

// File: rtl/des_round_controller.sv
// DES round sequencer: drives load/round/final strobes to an external datapath.
module des_round_controller
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic       i_decrypt,
  output logic       o_ready,
  output logic       o_valid,
  input  logic       i_ready,
  input  logic       i_abort,
  output logic       o_load,
  output logic       o_round_en,
  output logic [3:0] o_round_idx,
  output logic [1:0] o_shift_amt,
  output logic       o_shift_dir,
  output logic       o_final,
  output logic       o_busy
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       mode;

  // Counter is cleared whenever ROUND is left, so round_idx reads 0 outside ROUND.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      mode  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_valid && !i_abort) begin
          mode  <= i_decrypt;
          state <= LOAD;
        end
        LOAD: begin
          cnt   <= 4'd0;
          state <= i_abort ? IDLE : ROUND;
        end
        ROUND: begin
          if (i_abort) begin
            cnt   <= 4'd0;
            state <= IDLE;
          end else if (cnt == LAST_IDX) begin
            cnt   <= 4'd0;
            state <= FINAL;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FINAL: state <= i_abort ? IDLE : DONE;
        DONE:  if (i_ready || i_abort) state <= IDLE;
        default: begin
          cnt   <= 4'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_ready     = (state == IDLE);
  assign o_busy      = (state != IDLE);
  assign o_load      = (state == LOAD);
  assign o_round_en  = (state == ROUND);
  assign o_final     = (state == FINAL);
  assign o_valid     = (state == DONE);
  assign o_round_idx = cnt;

  des_shift_schedule u_sched (
    .round_idx (cnt),
    .mode      (mode),
    .round_en  (o_round_en),
    .shift_amt (o_shift_amt),
    .shift_dir (o_shift_dir)
  );

endmodule

// File: tb/tb_des_round_controller.sv
// Directed bench for des_round_controller with NUM_ROUNDS=16.
module tb_des_round_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid, i_decrypt, i_ready, i_abort;
  logic       o_ready, o_valid, o_load, o_round_en, o_shift_dir, o_final, o_busy;
  logic [3:0] o_round_idx;
  logic [1:0] o_shift_amt;

  int checks = 0;
  int errors = 0;

  int enc_tbl [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int dec_tbl [16] = '{0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  always #5 clk = ~clk;

  des_round_controller #(.NUM_ROUNDS(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .i_decrypt   (i_decrypt),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .i_abort     (i_abort),
    .o_load      (o_load),
    .o_round_en  (o_round_en),
    .o_round_idx (o_round_idx),
    .o_shift_amt (o_shift_amt),
    .o_shift_dir (o_shift_dir),
    .o_final     (o_final),
    .o_busy      (o_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_decrypt = 1'b0; i_ready = 1'b1; i_abort = 1'b0;
    #12;
    checks++;
    if ({o_ready, o_busy, o_load, o_round_en, o_final, o_valid} !== 6'b100000 ||
        o_round_idx !== 4'd0 || o_shift_amt !== 2'd0 || o_shift_dir !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b load=%b ren=%b fin=%b vld=%b idx=%0d amt=%0d",
               o_ready, o_busy, o_load, o_round_en, o_final, o_valid, o_round_idx, o_shift_amt);
    end
    @(negedge clk);
    rst = 1'b0;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_load !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL first_accept: load=%b busy=%b expected 1 1", o_load, o_busy);
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_round_en !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_load: ready=%b round_en=%b expected 1 0", o_ready, o_round_en);
    end
  endtask

  // Runs one full block from IDLE and checks every cycle through return to IDLE.
  task automatic test_block(input bit dec, input string name);
    int bad;
    i_decrypt = dec; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    checks++;
    if (o_load !== 1'b1 || o_round_en !== 1'b0 || o_final !== 1'b0) begin
      errors++;
      $display("FAIL %s_load: load=%b ren=%b fin=%b expected 1 0 0", name, o_load, o_round_en, o_final);
    end
    bad = 0;
    for (int r = 0; r < 16; r++) begin
      tick();
      i_decrypt = ~i_decrypt;
      if (o_round_en !== 1'b1 || o_load !== 1'b0 || o_final !== 1'b0 ||
          o_round_idx !== 4'(r) ||
          o_shift_amt !== 2'(dec ? dec_tbl[r] : enc_tbl[r]) || o_shift_dir !== dec) begin
        bad++;
        $display("FAIL %s_round%0d: ren=%b idx=%0d amt=%0d dir=%b expected 1 %0d %0d %b", name, r,
                 o_round_en, o_round_idx, o_shift_amt, o_shift_dir, r,
                 dec ? dec_tbl[r] : enc_tbl[r], dec);
      end
    end
    checks++;
    if (bad != 0) errors++;
    tick();
    checks++;
    if (o_final !== 1'b1 || o_round_en !== 1'b0 || o_valid !== 1'b0 || o_shift_amt !== 2'd0) begin
      errors++;
      $display("FAIL %s_final: fin=%b ren=%b vld=%b amt=%0d expected 1 0 0 0", name,
               o_final, o_round_en, o_valid, o_shift_amt);
    end
    tick();
    checks++;
    if (o_valid !== 1'b1 || o_final !== 1'b0 || o_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid_at_18: vld=%b fin=%b rdy=%b expected 1 0 0", name, o_valid, o_final, o_ready);
    end
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_return_idle: rdy=%b vld=%b busy=%b expected 1 0 0", name, o_ready, o_valid, o_busy);
    end
  endtask

  task automatic test_encrypt();
    test_block(1'b0, "enc");
  endtask

  task automatic test_decrypt();
    test_block(1'b1, "dec");
  endtask

  task automatic test_backpressure();
    i_decrypt = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    repeat (18) tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b rdy=%b expected 1 0", c, o_valid, o_ready);
      end
      i_valid = c[0];
      tick();
    end
    i_valid = 1'b0;
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_still_valid: vld=%b expected 1", o_valid);
    end
    i_ready = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_load !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b load=%b expected 1 0 0", o_ready, o_valid, o_load);
    end
  endtask

  task automatic test_abort();
    int seen;
    i_decrypt = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (8) tick();
    checks++;
    if (o_round_idx !== 4'd7 || o_round_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach_idx7: idx=%0d ren=%b expected 7 1", o_round_idx, o_round_en);
    end
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_round_idx !== 4'd0) begin
      errors++;
      $display("FAIL abort_to_idle: rdy=%b busy=%b idx=%0d expected 1 0 0", o_ready, o_busy, o_round_idx);
    end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_final || o_valid || o_busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: active cycles=%0d expected 0", seen);
    end
    // Abort while the block's own valid is also high in IDLE blocks acceptance.
    i_valid = 1'b1; i_abort = 1'b1;
    tick();
    checks++;
    if (o_load !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_blocks_accept: load=%b rdy=%b expected 0 1", o_load, o_ready);
    end
    i_valid = 1'b0; i_abort = 1'b0;
    test_block(1'b0, "post_abort");
    // Abort in DONE discards the result.
    i_valid = 1'b1; i_ready = 1'b0;
    tick();
    i_valid = 1'b0;
    repeat (18) tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0; i_ready = 1'b1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_in_done: vld=%b rdy=%b expected 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    i_decrypt = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    repeat (11) tick();
    checks++;
    if (o_round_idx !== 4'd10) begin
      errors++;
      $display("FAIL rst_reach_idx10: idx=%0d expected 10", o_round_idx);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_ready, o_busy, o_round_en, o_final, o_valid} !== 5'b10000 ||
        o_round_idx !== 4'd0 || o_shift_amt !== 2'd0 || o_shift_dir !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_clear: rdy=%b busy=%b ren=%b idx=%0d amt=%0d dir=%b expected 1 0 0 0 0 0",
               o_ready, o_busy, o_round_en, o_round_idx, o_shift_amt, o_shift_dir);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_final || o_valid || o_busy || !o_ready) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_abandon: bad cycles=%0d expected 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int  accepts [$];
    int  bad;
    bit  mode;
    bit  pre_rdy, pre_dec;
    i_valid = 1'b1; i_ready = 1'b1; i_decrypt = 1'b0; mode = 1'b0;
    bad = 0;
    for (int c = 0; c < 62; c++) begin
      pre_rdy = o_ready;
      pre_dec = i_decrypt;
      tick();
      if (pre_rdy) begin
        mode = pre_dec;
        accepts.push_back(c);
      end
      if (o_load !== pre_rdy) begin
        bad++;
        $display("FAIL b2b_load_c%0d: load=%b expected %b", c, o_load, pre_rdy);
      end
      if (o_round_en && (o_shift_amt !== 2'(mode ? dec_tbl[o_round_idx] : enc_tbl[o_round_idx]) ||
                         o_shift_dir !== mode)) begin
        bad++;
        $display("FAIL b2b_shift_c%0d: idx=%0d amt=%0d dir=%b mode=%b", c, o_round_idx,
                 o_shift_amt, o_shift_dir, mode);
      end
      i_decrypt = ~i_decrypt;
    end
    i_valid = 1'b0;
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (accepts.size() != 4 || accepts[1] - accepts[0] != 20 || accepts[2] - accepts[1] != 20 ||
        accepts[3] - accepts[2] != 20) begin
      errors++;
      $display("FAIL b2b_interval: accepts=%0d first_gaps=%0d,%0d expected 4 20,20", accepts.size(),
               accepts.size() > 1 ? accepts[1] - accepts[0] : -1,
               accepts.size() > 2 ? accepts[2] - accepts[1] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
